mem_arbiter: RTL and testbench

Two-port arbiter that shares the single core memory port (`mem_ctrl` / `mem_addr` / `mem_din` / `mem_dout`) between an instruction-fetch requester (port 0) and a load/store requester (port 1). It sits between the core front end and the memory model or RAM. Each requester uses a req/ack handshake. The arbiter registers the winning command onto the memory bus and returns read data with a one-cycle ack pulse. At most one transaction is in flight at a time.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one registered memory command port.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise port 1 has fixed priority.

package types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        MEM_CTRL_NONE       = 3'd0,
        MEM_CTRL_READ       = 3'd1,
        MEM_CTRL_READ_HALF  = 3'd2,
        MEM_CTRL_READ_BYTE  = 3'd3,
        MEM_CTRL_WRITE      = 3'd4,
        MEM_CTRL_WRITE_HALF = 3'd5,
        MEM_CTRL_WRITE_BYTE = 3'd6
    } mem_ctrl_t;

endpackage

module mem_arbiter
    import types_pkg::*;
(
    input  logic      clk,
    input  logic      rst,

    input  logic      p0_req,
    input  mem_ctrl_t p0_ctrl,
    input  word_t     p0_addr,
    input  word_t     p0_din,
    output word_t     p0_dout,
    output logic      p0_ack,

    input  logic      p1_req,
    input  mem_ctrl_t p1_ctrl,
    input  word_t     p1_addr,
    input  word_t     p1_din,
    output word_t     p1_dout,
    output logic      p1_ack,

    output mem_ctrl_t mem_ctrl,
    output word_t     mem_addr,
    output word_t     mem_din,
    input  word_t     mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t    state_q,    state_d;
    logic      grant_q,    grant_d;
    mem_ctrl_t mem_ctrl_q, mem_ctrl_d;
    word_t     mem_addr_q, mem_addr_d;
    word_t     mem_din_q,  mem_din_d;

    logic      pick_valid;
    logic      pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            // grant_q doubles as the round-robin last-grant pointer; 1 lets port 0 win first
            grant_q    <= 1'b1;
            mem_ctrl_q <= MEM_CTRL_NONE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mem_ctrl_d = MEM_CTRL_NONE;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        pick_valid = 1'b0;
        pick       = grant_q;
        p0_ack     = 1'b0;
        p1_ack     = 1'b0;
        p0_dout    = '0;
        p1_dout    = '0;

        case (state_q)
            IDLE: begin
                pick_valid = p0_req | p1_req;
                if (p0_req && p1_req) begin
`ifdef MEM_ARB_RR_EN
                    pick = ~grant_q;
`else
                    pick = 1'b1;
`endif
                end else begin
                    pick = p1_req;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                // the port being acked is masked, so only the other one may be issued
                state_d    = IDLE;
                pick       = ~grant_q;
                pick_valid = grant_q ? p0_req : p1_req;
                p0_ack     = ~grant_q;
                p1_ack     = grant_q;
                p0_dout    = grant_q ? '0 : mem_dout;
                p1_dout    = grant_q ? mem_dout : '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pick_valid) begin
            state_d    = ISSUE;
            grant_d    = pick;
            mem_ctrl_d = pick ? p1_ctrl : p0_ctrl;
            mem_addr_d = pick ? p1_addr : p0_addr;
            mem_din_d  = pick ? p1_din  : p0_din;
        end
    end

    assign mem_ctrl = mem_ctrl_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference; honours MEM_ARB_RR_EN like the design.

module tb_mem_arbiter;
    import types_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst;
    logic      p0_req, p1_req, p0_ack, p1_ack;
    mem_ctrl_t p0_ctrl, p1_ctrl, mem_ctrl;
    word_t     p0_addr, p0_din, p0_dout, p1_addr, p1_din, p1_dout;
    word_t     mem_addr, mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] env_mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_ctrl(p0_ctrl), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_dout(p0_dout), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_ctrl(p1_ctrl), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_dout(p1_dout), .p1_ack(p1_ack),
        .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory model: executes the command on the edge that samples it, little-endian.
    always @(posedge clk) begin
        logic [7:0] a;
        a = mem_addr[7:0];
        case (mem_ctrl)
            MEM_CTRL_READ:       mem_dout <= {env_mem[a + 8'd3], env_mem[a + 8'd2], env_mem[a + 8'd1], env_mem[a]};
            MEM_CTRL_READ_HALF:  mem_dout <= {16'h0000, env_mem[a + 8'd1], env_mem[a]};
            MEM_CTRL_READ_BYTE:  mem_dout <= {24'h000000, env_mem[a]};
            MEM_CTRL_WRITE: begin
                env_mem[a]        = mem_din[7:0];
                env_mem[a + 8'd1] = mem_din[15:8];
                env_mem[a + 8'd2] = mem_din[23:16];
                env_mem[a + 8'd3] = mem_din[31:24];
            end
            MEM_CTRL_WRITE_HALF: begin
                env_mem[a]        = mem_din[7:0];
                env_mem[a + 8'd1] = mem_din[15:8];
            end
            MEM_CTRL_WRITE_BYTE: env_mem[a] = mem_din[7:0];
            default: ;
        endcase
    end

    function automatic int nbytes(input mem_ctrl_t c);
        case (c)
            MEM_CTRL_READ, MEM_CTRL_WRITE:           return 4;
            MEM_CTRL_READ_HALF, MEM_CTRL_WRITE_HALF: return 2;
            MEM_CTRL_READ_BYTE, MEM_CTRL_WRITE_BYTE: return 1;
            default:                                 return 0;
        endcase
    endfunction

    function automatic bit is_read(input mem_ctrl_t c);
        return c inside {MEM_CTRL_READ, MEM_CTRL_READ_HALF, MEM_CTRL_READ_BYTE};
    endfunction

    // Reference access: applies a write to ref_mem or returns zero-extended read data.
    function automatic word_t ref_access(input mem_ctrl_t c, input word_t addr, input word_t din);
        word_t r;
        r = '0;
        for (int i = 0; i < nbytes(c); i++) begin
            int idx;
            idx = int'((addr + word_t'(i)) % 256);
            if (is_read(c)) r[8*i +: 8] = ref_mem[idx];
            else            ref_mem[idx] = din[8*i +: 8];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_ctrl = MEM_CTRL_NONE; p0_addr = '0; p0_din = '0;
        p1_req = 1'b0; p1_ctrl = MEM_CTRL_NONE; p1_addr = '0; p1_din = '0;
    endtask

    // Writes memory through port 1 and returns to IDLE.
    task automatic mem_poke(input mem_ctrl_t c, input word_t a, input word_t d);
        p1_req = 1'b1; p1_ctrl = c; p1_addr = a; p1_din = d;
        step();
        for (int i = 0; i < 6 && p1_ack !== 1'b1; i++) step();
        checks++;
        if (p1_ack !== 1'b1) begin errors++; $display("FAIL poke_ack: got %b expected 1", p1_ack); end
        p1_req = 1'b0; p1_ctrl = MEM_CTRL_NONE;
        step();
    endtask

    task automatic new_cmd(output mem_ctrl_t c, output word_t a, output word_t d);
        c = mem_ctrl_t'($urandom_range(0, 6));
        a = word_t'($urandom_range(0, 255));
        if (c inside {MEM_CTRL_READ, MEM_CTRL_WRITE}) a[1:0] = 2'b00;
        else if (c inside {MEM_CTRL_READ_HALF, MEM_CTRL_WRITE_HALF}) a[0] = 1'b0;
        d = $urandom;
    endtask

    task automatic test_reset();
        int first;
        first = RR_MODE ? 0 : 1;
        rst = 1'b0;
        p0_req = 1'b1; p0_ctrl = MEM_CTRL_READ; p0_addr = 32'h10;
        p1_req = 1'b1; p1_ctrl = MEM_CTRL_READ; p1_addr = 32'h20;
        step(); step();
        checks++; if (mem_ctrl !== MEM_CTRL_NONE) begin errors++; $display("FAIL reset_ctrl: got %0d expected 0", mem_ctrl); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h expected 0", mem_din); end
        checks++; if ({p1_ack, p0_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {p1_ack, p0_ack}); end
        checks++; if (p0_dout !== 32'h0 || p1_dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h/%h expected 0/0", p0_dout, p1_dout); end
        rst = 1'b1;
        step();
        checks++; if (mem_ctrl !== MEM_CTRL_READ) begin errors++; $display("FAIL rel_ctrl: got %0d expected %0d", mem_ctrl, MEM_CTRL_READ); end
        checks++; if (mem_addr !== (first == 1 ? 32'h20 : 32'h10)) begin errors++; $display("FAIL rel_addr: got %h winner %0d", mem_addr, first); end
        p0_req = 1'b0; p1_req = 1'b0;
        step();
        checks++; if ({p1_ack, p0_ack} !== (first == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rel_ack: got %b winner %0d", {p1_ack, p0_ack}, first); end
        step();
        checks++; if ({p1_ack, p0_ack} !== 2'b00 || mem_ctrl !== MEM_CTRL_NONE) begin errors++; $display("FAIL rel_idle: acks %b ctrl %0d expected 00/0", {p1_ack, p0_ack}, mem_ctrl); end
        idle_inputs();
    endtask

    task automatic test_single_read();
        mem_poke(MEM_CTRL_WRITE, 32'h10, 32'h11223344);
        p0_req = 1'b1; p0_ctrl = MEM_CTRL_READ; p0_addr = 32'h10;
        step();
        checks++; if (mem_ctrl !== MEM_CTRL_READ || mem_addr !== 32'h10) begin errors++; $display("FAIL rd_issue: got %0d@%h expected 1@00000010", mem_ctrl, mem_addr); end
        checks++; if ({p1_ack, p0_ack} !== 2'b00) begin errors++; $display("FAIL rd_early_ack: got %b expected 00", {p1_ack, p0_ack}); end
        step();
        checks++; if ({p1_ack, p0_ack} !== 2'b01) begin errors++; $display("FAIL rd_ack: got %b expected 01", {p1_ack, p0_ack}); end
        checks++; if (p0_dout !== 32'h11223344) begin errors++; $display("FAIL rd_data: got %h expected 11223344", p0_dout); end
        checks++; if (p1_dout !== 32'h0) begin errors++; $display("FAIL rd_other_dout: got %h expected 0", p1_dout); end
        checks++; if (mem_ctrl !== MEM_CTRL_NONE) begin errors++; $display("FAIL rd_resp_ctrl: got %0d expected 0", mem_ctrl); end
        p0_req = 1'b0;
        step();
        checks++; if ({p1_ack, p0_ack} !== 2'b00) begin errors++; $display("FAIL rd_after: got %b expected 00", {p1_ack, p0_ack}); end
    endtask

    task automatic test_subword();
        mem_poke(MEM_CTRL_WRITE_BYTE, 32'h20, 32'h000000CD);
        p1_req = 1'b1; p1_ctrl = MEM_CTRL_WRITE_BYTE; p1_addr = 32'h21; p1_din = 32'h123456AB;
        step();
        for (int i = 0; i < 6 && p1_ack !== 1'b1; i++) step();
        checks++; if (p1_ack !== 1'b1) begin errors++; $display("FAIL sb_wr_ack: got %b expected 1", p1_ack); end
        p1_ctrl = MEM_CTRL_READ_HALF; p1_addr = 32'h20;
        step();
        for (int i = 0; i < 6 && p1_ack !== 1'b1; i++) step();
        checks++; if (p1_ack !== 1'b1) begin errors++; $display("FAIL sb_rh_ack: got %b expected 1", p1_ack); end
        checks++; if (p1_dout !== 32'h0000ABCD) begin errors++; $display("FAIL sb_rh_data: got %h expected 0000abcd", p1_dout); end
        p1_ctrl = MEM_CTRL_READ_BYTE; p1_addr = 32'h21;
        step();
        for (int i = 0; i < 6 && p1_ack !== 1'b1; i++) step();
        checks++; if (p1_ack !== 1'b1) begin errors++; $display("FAIL sb_rb_ack: got %b expected 1", p1_ack); end
        checks++; if (p1_dout !== 32'h000000AB) begin errors++; $display("FAIL sb_rb_data: got %h expected 000000ab", p1_dout); end
        idle_inputs();
        step();
    endtask

    task automatic test_contention();
        int first;
        first = RR_MODE ? 0 : 1;
        p1_req = 1'b1; p1_ctrl = MEM_CTRL_READ; p1_addr = 32'h20;
        step(); step();
        checks++; if ({p1_ack, p0_ack} !== 2'b10) begin errors++; $display("FAIL ct_solo_ack: got %b expected 10", {p1_ack, p0_ack}); end
        p1_req = 1'b0;
        step();
        p0_req = 1'b1; p0_ctrl = MEM_CTRL_READ; p0_addr = 32'h10;
        p1_req = 1'b1; p1_ctrl = MEM_CTRL_READ; p1_addr = 32'h20;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] exp;
            step();
            exp = 2'b00;
            if (k == 2) exp = (first == 1) ? 2'b10 : 2'b01;
            if (k == 4) exp = (first == 1) ? 2'b01 : 2'b10;
            checks++; if ({p1_ack, p0_ack} !== exp) begin errors++; $display("FAIL ct_ack_c%0d: got %b expected %b", k, {p1_ack, p0_ack}, exp); end
            if (exp[0]) begin
                checks++; if (p0_dout !== 32'h11223344) begin errors++; $display("FAIL ct_p0_data: got %h expected 11223344", p0_dout); end
                p0_req = 1'b0;
            end
            if (exp[1]) begin
                checks++; if (p1_dout !== 32'h0000ABCD) begin errors++; $display("FAIL ct_p1_data: got %h expected 0000abcd", p1_dout); end
                p1_req = 1'b0;
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_continuous();
        int first;
        int n_acks;
        first = RR_MODE ? 0 : 1;
        n_acks = 0;
        p0_req = 1'b1; p0_ctrl = MEM_CTRL_READ; p0_addr = 32'h10;
        p1_req = 1'b1; p1_ctrl = MEM_CTRL_READ; p1_addr = 32'h20;
        for (int k = 1; k <= 12; k++) begin
            logic [1:0] exp;
            int port;
            step();
            exp = 2'b00;
            if (k % 2 == 0) begin
                port = (((k / 2) - 1) % 2 == 0) ? first : 1 - first;
                exp = (port == 1) ? 2'b10 : 2'b01;
            end
            if (p0_ack === 1'b1) n_acks++;
            if (p1_ack === 1'b1) n_acks++;
            checks++; if ({p1_ack, p0_ack} !== exp) begin errors++; $display("FAIL cc_ack_c%0d: got %b expected %b", k, {p1_ack, p0_ack}, exp); end
            checks++; if ((mem_ctrl != MEM_CTRL_NONE) !== (k % 2 == 1)) begin errors++; $display("FAIL cc_ctrl_c%0d: got %0d", k, mem_ctrl); end
        end
        checks++; if (n_acks != 6) begin errors++; $display("FAIL cc_total: got %0d acks expected 6", n_acks); end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_abort();
        p1_req = 1'b1; p1_ctrl = MEM_CTRL_WRITE; p1_addr = 32'h40; p1_din = 32'hDEADBEEF;
        step();
        checks++; if (mem_ctrl !== MEM_CTRL_WRITE) begin errors++; $display("FAIL ab_issue: got %0d expected %0d", mem_ctrl, MEM_CTRL_WRITE); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_ctrl !== MEM_CTRL_NONE || mem_addr !== 32'h0 || mem_din !== 32'h0) begin errors++; $display("FAIL ab_async: got %0d %h %h expected 0 0 0", mem_ctrl, mem_addr, mem_din); end
        checks++; if ({p1_ack, p0_ack} !== 2'b00) begin errors++; $display("FAIL ab_async_ack: got %b expected 00", {p1_ack, p0_ack}); end
        step();
        checks++; if ({p1_ack, p0_ack} !== 2'b00 || mem_ctrl !== MEM_CTRL_NONE) begin errors++; $display("FAIL ab_hold: acks %b ctrl %0d expected 00/0", {p1_ack, p0_ack}, mem_ctrl); end
        rst = 1'b1;
        step();
        checks++; if (mem_ctrl !== MEM_CTRL_WRITE || p1_ack !== 1'b0) begin errors++; $display("FAIL ab_reissue: ctrl %0d ack %b expected %0d/0", mem_ctrl, p1_ack, MEM_CTRL_WRITE); end
        step();
        checks++; if (p1_ack !== 1'b1) begin errors++; $display("FAIL ab_ack: got %b expected 1", p1_ack); end
        p1_req = 1'b0;
        step();
        p0_req = 1'b1; p0_ctrl = MEM_CTRL_READ; p0_addr = 32'h40;
        step();
        for (int i = 0; i < 6 && p0_ack !== 1'b1; i++) step();
        checks++; if (p0_ack !== 1'b1 || p0_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL ab_readback: ack %b data %h expected 1/deadbeef", p0_ack, p0_dout); end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        int m_issue, m_resp, m_last, w;
        mem_ctrl_t m_ctrl, m_resp_ctrl, exp_ctrl;
        word_t m_addr, m_din, m_exp;
        bit c0, c1;
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = env_mem[i];
        m_issue = -1; m_resp = -1; m_last = 1;
        m_ctrl = MEM_CTRL_NONE; m_resp_ctrl = MEM_CTRL_NONE;
        m_addr = '0; m_din = '0; m_exp = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_ctrl = (m_issue >= 0) ? m_ctrl : MEM_CTRL_NONE;
            checks++; if (p0_ack !== (m_resp == 0)) begin errors++; $display("FAIL rnd_p0_ack c%0d: got %b expected %b", cyc, p0_ack, m_resp == 0); end
            checks++; if (p1_ack !== (m_resp == 1)) begin errors++; $display("FAIL rnd_p1_ack c%0d: got %b expected %b", cyc, p1_ack, m_resp == 1); end
            checks++; if (mem_ctrl !== exp_ctrl) begin errors++; $display("FAIL rnd_ctrl c%0d: got %0d expected %0d", cyc, mem_ctrl, exp_ctrl); end
            if (m_issue >= 0) begin
                checks++; if (mem_addr !== m_addr || mem_din !== m_din) begin errors++; $display("FAIL rnd_bus c%0d: got %h/%h expected %h/%h", cyc, mem_addr, mem_din, m_addr, m_din); end
            end
            if (m_resp >= 0 && is_read(m_resp_ctrl)) begin
                checks++; if ((m_resp == 0 ? p0_dout : p1_dout) !== m_exp) begin errors++; $display("FAIL rnd_data c%0d: port %0d got %h expected %h", cyc, m_resp, (m_resp == 0 ? p0_dout : p1_dout), m_exp); end
            end
            if (m_resp != 0) begin
                checks++; if (p0_dout !== 32'h0) begin errors++; $display("FAIL rnd_p0_zero c%0d: got %h expected 0", cyc, p0_dout); end
            end
            if (m_resp != 1) begin
                checks++; if (p1_dout !== 32'h0) begin errors++; $display("FAIL rnd_p1_zero c%0d: got %h expected 0", cyc, p1_dout); end
            end

            if (m_resp == 0) begin
                if ($urandom_range(0, 1) == 1) p0_req = 1'b0;
                else new_cmd(p0_ctrl, p0_addr, p0_din);
            end else if (!p0_req && $urandom_range(0, 9) < 4) begin
                p0_req = 1'b1; new_cmd(p0_ctrl, p0_addr, p0_din);
            end
            if (m_resp == 1) begin
                if ($urandom_range(0, 1) == 1) p1_req = 1'b0;
                else new_cmd(p1_ctrl, p1_addr, p1_din);
            end else if (!p1_req && $urandom_range(0, 9) < 4) begin
                p1_req = 1'b1; new_cmd(p1_ctrl, p1_addr, p1_din);
            end

            if (m_issue >= 0) begin
                m_exp = ref_access(m_ctrl, m_addr, m_din);
                m_resp_ctrl = m_ctrl;
                m_resp = m_issue;
                m_issue = -1;
            end else begin
                c0 = p0_req && (m_resp != 0);
                c1 = p1_req && (m_resp != 1);
                if (c0 && c1) w = RR_MODE ? 1 - m_last : 1;
                else if (c1)  w = 1;
                else if (c0)  w = 0;
                else          w = -1;
                m_resp = -1;
                if (w >= 0) begin
                    m_issue = w;
                    m_last  = w;
                    m_ctrl  = (w == 1) ? p1_ctrl : p0_ctrl;
                    m_addr  = (w == 1) ? p1_addr : p0_addr;
                    m_din   = (w == 1) ? p1_din  : p0_din;
                end
            end
            step();
        end
        idle_inputs();
        step(); step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_subword();
        test_contention();
        test_continuous();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
